// File: rtl/alu_pkg.sv
// Shared constants and payload types for the shared add/sub unit and its arbiter.
package alu_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned DEF_CNT_W = 8;

    localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

    localparam int unsigned REQ0 = 0;
    localparam int unsigned REQ1 = 1;

    // Operation presented to the shared adder
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              sub;
    } op_t;

    // Result held in a response buffer
    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              ovfl;
    } res_t;

endpackage

// File: rtl/adder.sv
// 16-bit two's complement saturating add/sub; combinational.
module adder
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              ovfl
);

    logic [DATA_W:0] ext_a;
    logic [DATA_W:0] ext_b;
    logic [DATA_W:0] raw;

    // One extra sign bit gives the true result sign; overflow when it disagrees with bit 15
    always_comb begin
        ext_a = {a[DATA_W-1], a};
        ext_b = {b[DATA_W-1], b};
        raw   = sub ? (ext_a - ext_b) : (ext_a + ext_b);
        ovfl  = raw[DATA_W] ^ raw[DATA_W-1];
        sum   = raw[DATA_W-1:0];
        if (ovfl) begin
            sum = raw[DATA_W] ? SAT_NEG : SAT_POS;
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last_grant resets to 1 so input 0 wins first contention.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig,
    output logic [1:0] gnt
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant selection and last-grant tracking
    always_comb begin
        gnt          = 2'b00;
        last_grant_d = last_grant_q;
        if (elig == 2'b11) begin
            gnt = last_grant_q ? 2'b01 : 2'b10;
        end else begin
            gnt = elig;
        end
        if (gnt[1]) begin
            last_grant_d = 1'b1;
        end else if (gnt[0]) begin
            last_grant_d = 1'b0;
        end
    end

    // Last-grant register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one saturating add/sub unit between two requesters with per-requester response buffers.
module adder_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_sub,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_sub,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_sum,
    output logic              rsp0_ovfl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_sum,
    output logic              rsp1_ovfl,
    output logic [CNT_W-1:0]  ovfl_cnt,
    input  logic              cnt_clr
);

    logic [1:0]       elig_c;
    logic [1:0]       gnt_c;
    op_t              op_c;
    res_t             res_c;
    logic [1:0]       rsp_ready_c;

    logic [1:0]       rsp_valid_q;
    logic [1:0]       rsp_valid_d;
    res_t [1:0]       rsp_res_q;
    res_t [1:0]       rsp_res_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Eligibility: request pending and its buffer free or draining this cycle; nothing during reset
    always_comb begin
        rsp_ready_c       = {rsp1_ready, rsp0_ready};
        elig_c[REQ0]      = rst_n & req0_valid & (~rsp_valid_q[REQ0] | rsp_ready_c[REQ0]);
        elig_c[REQ1]      = rst_n & req1_valid & (~rsp_valid_q[REQ1] | rsp_ready_c[REQ1]);
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .elig  (elig_c),
        .gnt   (gnt_c)
    );

    // Operand mux: requester 0 unless requester 1 is granted
    always_comb begin
        op_c = '{a: req0_a, b: req0_b, sub: req0_sub};
        if (gnt_c[REQ1]) begin
            op_c = '{a: req1_a, b: req1_b, sub: req1_sub};
        end
    end

    adder u_adder (
        .a    (op_c.a),
        .b    (op_c.b),
        .sub  (op_c.sub),
        .sum  (res_c.sum),
        .ovfl (res_c.ovfl)
    );

    // Response buffers: load on grant, else clear on drain, else hold
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        for (int i = 0; i < 2; i++) begin
            rsp_valid_d[i] = gnt_c[i] | (rsp_valid_q[i] & ~rsp_ready_c[i]);
            if (gnt_c[i]) begin
                rsp_res_d[i] = res_c;
            end
        end
    end

    // Overflow event counter: clear wins, saturates at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if ((|gnt_c) && res_c.ovfl && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_res_q   <= '0;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req0_ready = gnt_c[REQ0];
    assign req1_ready = gnt_c[REQ1];
    assign rsp0_valid = rsp_valid_q[REQ0];
    assign rsp0_sum   = rsp_res_q[REQ0].sum;
    assign rsp0_ovfl  = rsp_res_q[REQ0].ovfl;
    assign rsp1_valid = rsp_valid_q[REQ1];
    assign rsp1_sum   = rsp_res_q[REQ1].sum;
    assign rsp1_ovfl  = rsp_res_q[REQ1].ovfl;
    assign ovfl_cnt   = cnt_q;

endmodule
